// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. Consumes the 5-bit ALU control code produced in ID,
// applies it to two XLEN-wide operands and hands a registered result plus a
// branch decision to the EX/MEM register. Both sides use a valid/ready
// handshake. Non-shift operations complete in one cycle. Shifts run serially
// (one bit position per cycle) unless ALU_EXEC_BARREL_SHIFT_EN is defined,
// in which case they use a single-cycle barrel shifter and every operation
// has 1-cycle latency. Results are identical in both builds.
//
// Build option:
//   ALU_EXEC_BARREL_SHIFT_EN  - single-cycle barrel shifter (SHIFT unused).
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_flush         synchronous abort of the in-flight/pending operation
//   i_valid         operation request valid
//   o_ready         unit can accept an operation this cycle
//   i_alu_ctrl      ALU control code (0-31)
//   i_op_a          operand A (rs1 or PC)
//   i_op_b          operand B (rs2 or immediate)
//   o_valid         result valid
//   i_ready         downstream accepts result
//   o_result        operation result
//   o_branch_taken  branch condition true (codes 10-15 only)
//   o_zero          o_result == 0
//   o_illegal       a code in 21-31 was executed
//   o_busy          unit not idle
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int  XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_alu_ctrl,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_branch_taken,
    output logic            o_zero,
    output logic            o_illegal,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t          r_state;
    logic [XLEN-1:0] r_result;
    logic            r_branch;
    logic            r_illegal;
    logic [XLEN-1:0] r_shreg;
    logic [SHW-1:0]  r_cnt;
    logic            r_sh_left;
    logic            r_sh_arith;

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_diff;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [XLEN-1:0] w_alu_result;
    logic            w_branch;
    logic            w_illegal;
    logic            w_start_shift;
    logic            w_accept;
    logic [XLEN-1:0] w_shift_next;

    // Upper bits of B are deliberately ignored for shifts.
    assign w_shamt = i_op_b[SHW-1:0];
    assign w_diff  = i_op_a - i_op_b;
    assign w_eq    = (i_op_a == i_op_b);
    assign w_lt_s  = ($signed(i_op_a) < $signed(i_op_b));
    assign w_lt_u  = (i_op_a < i_op_b);

    // Single-cycle datapath. In the serial build a shift is only started when
    // the amount is non-zero; a zero-amount shift simply returns A.
    always_comb begin
        w_alu_result  = '0;
        w_branch      = 1'b0;
        w_illegal     = 1'b0;
        w_start_shift = 1'b0;
        case (i_alu_ctrl)
            5'd0:  w_alu_result = i_op_a & i_op_b;
            5'd1:  w_alu_result = i_op_a | i_op_b;
            5'd2:  w_alu_result = i_op_a ^ i_op_b;
            5'd3:  w_alu_result = i_op_a + i_op_b;
            5'd4:  w_alu_result = w_diff;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            5'd5:  w_alu_result = i_op_a << w_shamt;
            5'd6:  w_alu_result = i_op_a >> w_shamt;
            5'd9:  w_alu_result = $signed(i_op_a) >>> w_shamt;
`else
            5'd5, 5'd6, 5'd9: begin
                w_alu_result  = i_op_a;
                w_start_shift = (w_shamt != '0);
            end
`endif
            5'd7:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_s};
            5'd8:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt_u};
            5'd10: begin w_alu_result = w_diff; w_branch = w_eq;    end
            5'd11: begin w_alu_result = w_diff; w_branch = ~w_eq;   end
            5'd12: begin w_alu_result = w_diff; w_branch = w_lt_s;  end
            5'd13: begin w_alu_result = w_diff; w_branch = w_lt_u;  end
            5'd14: begin w_alu_result = w_diff; w_branch = ~w_lt_s; end
            5'd15: begin w_alu_result = w_diff; w_branch = ~w_lt_u; end
            5'd16: w_alu_result = i_op_b;
            5'd17: w_alu_result = i_op_a + i_op_b;
            5'd18, 5'd19, 5'd20: w_alu_result = '0;
            default: w_illegal = 1'b1;
        endcase
    end

    // One-position step of the serial shifter; SRA refills with the MSB.
    always_comb begin
        if (r_sh_left) begin
            w_shift_next = {r_shreg[XLEN-2:0], 1'b0};
        end else begin
            w_shift_next = {r_sh_arith & r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
        end
    end

    // In DONE the unit can take a new op only in the cycle the current result
    // leaves, which is what makes back-to-back 1 op/cycle possible.
    always_comb begin
        case (r_state)
            ST_IDLE: o_ready = 1'b1;
            ST_DONE: o_ready = i_ready;
            default: o_ready = 1'b0;
        endcase
    end

    assign w_accept = i_valid & o_ready & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sh_left  <= (i_alu_ctrl == 5'd5);
            r_sh_arith <= (i_alu_ctrl == 5'd9);
            if (w_start_shift) begin
                r_shreg   <= i_op_a;
                r_cnt     <= w_shamt;
                r_branch  <= 1'b0;
                r_illegal <= 1'b0;
                r_state   <= ST_SHIFT;
            end else begin
                r_result  <= w_alu_result;
                r_branch  <= w_branch;
                r_illegal <= w_illegal;
                r_state   <= ST_DONE;
            end
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - CNT_ONE;
                    // The final bit moves in the same cycle the counter hits 0.
                    if (r_cnt == CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Accept-in-DONE is handled above; here only drain.
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid        = (r_state == ST_DONE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_result       = r_result;
    assign o_branch_taken = r_branch;
    assign o_illegal      = r_illegal;
    assign o_zero         = (r_result == '0);

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 5-bit ALU control code produced in ID. Performs the coded operation on two XLEN operands and returns a result plus a branch decision.
- Uses a valid/ready handshake on both sides. Shifts run serially, one bit per cycle, to save area; all other ops complete in one cycle.
- Sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- i_flush  input  1  synchronous abort of in-flight op.
- i_valid  input  1  operation request valid.
- o_ready  output  1  unit can accept an operation this cycle.
- i_alu_ctrl  input  5  ALU control code.
- i_op_a  input  XLEN  operand A (rs1 or PC).
- i_op_b  input  XLEN  operand B (rs2 or immediate).
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  XLEN  operation result.
- o_branch_taken  output  1  branch condition true (codes 10-15 only).
- o_zero  output  1  o_result == 0.
- o_illegal  output  1  code 21-31 was executed.
- o_busy  output  1  state != IDLE.

Behaviour:
- Control codes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLL, 6 SRL, 7 SLT (signed), 8 SLTU, 9 SRA.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BLTU, 14 BGE, 15 BGEU.
  - 16 LUI (result = B), 17 AUIPC (result = A+B).
  - 18 FENCE, 19 ECALL, 20 EBREAK: result 0, no illegal flag.
  - 21-31: result 0, o_illegal = 1.
- Arithmetic: add/sub wrap modulo 2^XLEN. SLT/SLTU give result 0 or 1, zero-extended.
- Branch codes: o_result = A-B; o_branch_taken = comparison outcome. For all other codes o_branch_taken = 0.
- Shift amount = B[SHW-1:0]; upper bits of B are ignored.
- FSM states:
  - IDLE: o_ready=1. On i_valid, capture operands and code. Non-shift op: compute, register the result, go to DONE. Shift with shamt=0: result=A, go to DONE. Shift with shamt>0: load A into the shift register and shamt into a down-counter, go to SHIFT.
  - SHIFT: o_ready=0. Shift one position per cycle; SRA replicates the MSB. Decrement the counter; when it reaches 0 (the cycle the last bit moves), go to DONE.
  - DONE: o_valid=1; all result outputs held stable while i_ready=0. o_ready = i_ready (combinational). If i_ready & i_valid, accept the next op in the same cycle (back-to-back). If i_ready & !i_valid, go to IDLE.
- Latency (accept edge to o_valid): non-shift ops 1 cycle; shifts shamt+1 cycles. Back-to-back single-cycle ops sustain 1 op/cycle.
- i_flush: next state IDLE, o_valid drops next cycle, captured op discarded. Flush takes priority over a simultaneous i_valid (not accepted) and over a pending DONE.
- Reset, including mid-shift: state IDLE; o_valid, o_result, o_branch_taken, o_illegal, o_busy = 0; o_zero = 1; counter = 0.
- o_zero is derived from the registered o_result.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state is unused (unreachable), and every op has 1-cycle latency.
- Undefined: serial shifter as described above.
- Results must be identical in both builds; only latency differs.

Test Plan:
- ADD A=0xFFFFFFFF, B=1 -> o_result=0, o_zero=1, o_valid exactly 1 cycle after accept.
- SRA A=0x80000000, B=31 -> o_result=0xFFFFFFFF, o_valid at cycle 32 (serial build) or cycle 1 (barrel build); o_ready=0 while shifting.
- BLT A=0xFFFFFFFE (-2), B=1 -> o_branch_taken=1. BLTU with the same operands -> o_branch_taken=0.
- Three back-to-back XOR ops with i_ready held high -> three results on consecutive cycles, no bubbles. With i_ready=0 for 4 cycles, the result stays stable and o_ready=0.
- SLL A=1, B=10, i_flush pulsed at shift cycle 5 -> no o_valid; IDLE next cycle. Then SLL A=1, B=0x3F (shamt 31) -> 0x80000000.
- Code 25 -> o_illegal=1, o_result=0. Async i_rst_n low mid-SRL -> all outputs cleared immediately, o_busy=0.
